slow_mix_sat: RTL and testbench
===============================

Name: slow_mix_sat

Overview:
- Multi-channel audio mixer, successor to the single-lane sequential adder in the vibrato/effects chain.
- Each transaction accepts G_NUM_CH signed samples and applies a per-channel signed fixed-point gain and a channel enable mask.
- Accumulates G_LANES products per cycle, then rounds, rescales and saturates to G_DWIDTH.
- Sits between the effect taps (dry/delayed samples) and the output stage; reports clipping per sample and as a running count.

Parameters:
G_DWIDTH, 16, sample width (signed two's complement)
G_NUM_CH, 4, channels per transaction (>=1)
G_LANES, 2, products accumulated per cycle (1..G_NUM_CH)
G_GAIN_WIDTH, 16, signed gain width
G_GAIN_FRAC, 14, gain fractional bits (unity = 2**G_GAIN_FRAC; must be >=1)
G_CNT_WIDTH, 16, clip counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  0 = flush datapath/handshake (same as reset, except clip_count is held)
din  in  G_DWIDTH x G_NUM_CH (unpacked array)  input samples
gain  in  G_GAIN_WIDTH x G_NUM_CH (unpacked array)  per-channel signed gain
ch_mask  in  G_NUM_CH  1 = channel contributes
din_valid  in  1  input valid
din_ready  out  1  input ready
dout  out  G_DWIDTH  mixed, saturated sample
clip  out  1  dout was saturated; qualified by dout_valid
dout_valid  out  1  output valid
dout_ready  in  1  output ready
clip_count  out  G_CNT_WIDTH  saturating count of clipped outputs
clip_count_clr  in  1  synchronous clear of clip_count

Behaviour:
- Reset values: din_ready=0, dout_valid=0, dout=0, clip=0, clip_count=0, accumulator=0; state SM_INIT.
- enable=0 has the same effect, except clip_count holds its value. Reset or enable drop takes effect in any state; any in-flight transaction is discarded.
- States and transitions:
  - SM_INIT: din_ready<=1, go to SM_GET_INPUT.
  - SM_GET_INPUT: on din_valid&din_ready, latch din, gain and ch_mask (masked channels store product 0); clear the accumulator and lane index; din_ready<=0; go to SM_ACC.
  - SM_ACC: acc += sum of G_LANES products din_st[k]*gain_st[k], for k = idx .. idx+G_LANES-1.
    - Lane indices >= G_NUM_CH contribute 0.
    - idx += G_LANES each cycle. Stay ceil(G_NUM_CH/G_LANES) cycles, then go to SM_SCALE.
  - SM_SCALE:
    - r = (acc + 2**(G_GAIN_FRAC-1)) >>> G_GAIN_FRAC (round half up, arithmetic shift).
    - If r > 2**(G_DWIDTH-1)-1, dout = max and clip=1. If r < -2**(G_DWIDTH-1), dout = min and clip=1. Otherwise dout = r and clip=0.
    - dout_valid<=1; go to SM_SEND_OUTPUT.
  - SM_SEND_OUTPUT: on dout_valid&dout_ready, dout_valid<=0, din_ready<=1, go to SM_GET_INPUT. dout and clip hold stable while stalled.
- Latency: accept edge T → dout_valid high after edge T+ceil(G_NUM_CH/G_LANES)+1.
- Throughput: one transaction per ceil(G_NUM_CH/G_LANES)+3 cycles with dout_ready held high.
- Widths:
  - product = G_DWIDTH+G_GAIN_WIDTH bits.
  - acc = G_DWIDTH+G_GAIN_WIDTH+$clog2(G_NUM_CH)+1 bits. It never overflows.
- Inputs are sampled only at the accept edge. gain and ch_mask changes mid-transaction have no effect on that transaction.
- clip_count increments by 1 on each SM_SCALE cycle with clip=1, saturating at all-ones.
- If clip_count_clr coincides with an increment, the clear wins and the count is 0.

Decomposition:
- Package slow_mix_pkg holds:
  - state_t enum (SM_INIT, SM_GET_INPUT, SM_ACC, SM_SCALE, SM_SEND_OUTPUT).
  - Function acc_width(dw, gw, n).
  - Function sat_round(acc, frac, dw) returning {clip, dout}.
- One sub-module, mix_sat_round: combinational round/shift/saturate used in SM_SCALE. Registered by the parent.

Test Plan (G_DWIDTH=16, G_NUM_CH=4, G_LANES=2, G_GAIN_FRAC=14, unity=16384):
1. Unity gains, mask 1111, din {100,200,-50,25}, accepted at edge T → dout=275, clip=0, dout_valid after edge T+3. A second back-to-back input gives identical timing.
2. Unity gains, din all 30000 → dout=32767, clip=1, clip_count=1. Then din all -30000 → dout=-32768, clip_count=2. Pulsing clip_count_clr → 0.
3. Gain 8192 (0.5) on ch0, din {3,0,0,0} → dout=2. Then din {-3,0,0,0} → dout=-1 (round half up).
4. Mask 0101, din {10,20,30,40}, unity gains → dout=40. Changing the gain on ch0 to 0 one cycle after accept → still 40.
5. dout_ready low for 5 cycles after dout_valid → dout and clip stable, din_ready=0, a held din_valid is not accepted. It is accepted on the cycle after the output handshake.
6. reset asserted mid-SM_ACC → all outputs at reset values next cycle. enable=0 after a clip → clip_count retained. The next transaction after recovery is correct ({1,1,1,1} → 4).

Source files
------------

// File: rtl/slow_mix_pkg.sv
// slow_mix_pkg: shared FSM states and width/rounding helpers for the mixer
package slow_mix_pkg;
  typedef enum logic [2:0] {SM_INIT, SM_GET_INPUT, SM_ACC, SM_SCALE, SM_SEND_OUTPUT} state_t;
  // Product width plus enough growth to sum n products without overflow
  function automatic int acc_width(input int dw, input int gw, input int n);
    return dw + gw + $clog2(n) + 1;
  endfunction
  // Round half up, arithmetic shift right by frac, saturate to dw bits; returns {clip, dout (sign-extended)}
  function automatic logic [64:0] sat_round(input logic signed [63:0] acc, input int frac, input int dw);
    logic signed [63:0] r, mx, mn;
    r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    mx = (64'sd1 <<< (dw - 1)) - 64'sd1;
    mn = -(64'sd1 <<< (dw - 1));
    return r > mx ? {1'b1, mx} : r < mn ? {1'b1, mn} : {1'b0, r};
  endfunction
endpackage

// File: rtl/mix_sat_round.sv
// mix_sat_round: combinational round/rescale/saturate of the accumulator
module mix_sat_round import slow_mix_pkg::*; #(
  parameter int G_AW   = 35,
  parameter int G_DW   = 16,
  parameter int G_FRAC = 14
) (
  input  logic signed [G_AW-1:0] i_acc,
  output logic signed [G_DW-1:0] o_dout,
  output logic                   o_clip
);
  logic [64:0] w_res;
  assign w_res  = sat_round(64'(i_acc), G_FRAC, G_DW);
  assign o_clip = w_res[64];
  assign o_dout = G_DW'(w_res[63:0]);
endmodule

// File: rtl/slow_mix_sat.sv
// slow_mix_sat: multi-lane gain/mask mixer with rounding, saturation and clip counting
module slow_mix_sat import slow_mix_pkg::*; #(
  parameter int G_DWIDTH     = 16,
  parameter int G_NUM_CH     = 4,
  parameter int G_LANES      = 2,
  parameter int G_GAIN_WIDTH = 16,
  parameter int G_GAIN_FRAC  = 14,
  parameter int G_CNT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic signed [G_DWIDTH-1:0]     din [G_NUM_CH],
  input  logic signed [G_GAIN_WIDTH-1:0] gain [G_NUM_CH],
  input  logic [G_NUM_CH-1:0]            ch_mask,
  input  logic                           din_valid,
  output logic                           din_ready,
  output logic signed [G_DWIDTH-1:0]     dout,
  output logic                           clip,
  output logic                           dout_valid,
  input  logic                           dout_ready,
  output logic [G_CNT_WIDTH-1:0]         clip_count,
  input  logic                           clip_count_clr
);
  localparam int AW = acc_width(G_DWIDTH, G_GAIN_WIDTH, G_NUM_CH);
  localparam int PW = G_DWIDTH + G_GAIN_WIDTH;
  localparam int IW = $clog2(G_NUM_CH + G_LANES + 1);
  state_t                         r_state, w_next;
  logic signed [G_DWIDTH-1:0]     r_din [G_NUM_CH];
  logic signed [G_GAIN_WIDTH-1:0] r_gain [G_NUM_CH];
  logic signed [AW-1:0]           r_acc, w_sum;
  logic [IW-1:0]                  r_idx;
  logic signed [G_DWIDTH-1:0]     w_dout;
  logic                           w_clip, w_last, w_flush;
  assign w_flush = reset || !enable;
  assign w_last  = int'(r_idx) + G_LANES >= G_NUM_CH;
  mix_sat_round #(.G_AW(AW), .G_DW(G_DWIDTH), .G_FRAC(G_GAIN_FRAC)) u_rnd (
    .i_acc(r_acc), .o_dout(w_dout), .o_clip(w_clip)
  );
  // State register; flush returns to SM_INIT discarding any transaction
  always_ff @(posedge clk)
    r_state <= w_flush ? SM_INIT : w_next;
  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      SM_INIT:        w_next = SM_GET_INPUT;
      SM_GET_INPUT:   w_next = din_valid ? SM_ACC : SM_GET_INPUT;
      SM_ACC:         w_next = w_last ? SM_SCALE : SM_ACC;
      SM_SCALE:       w_next = SM_SEND_OUTPUT;
      SM_SEND_OUTPUT: w_next = dout_ready ? SM_GET_INPUT : SM_SEND_OUTPUT;
      default:        w_next = SM_INIT;
    endcase
  end
  // Handshake outputs follow the state directly
  always_comb begin
    din_ready  = r_state == SM_GET_INPUT;
    dout_valid = r_state == SM_SEND_OUTPUT;
  end
  // Sum of the products in the current lane window; lanes past the last channel add nothing
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < G_NUM_CH; k++)
      if (k >= int'(r_idx) && k < int'(r_idx) + G_LANES)
        w_sum = w_sum + AW'(PW'(r_din[k]) * PW'(r_gain[k]));
  end
  // Datapath: capture on accept, accumulate lanes, register the saturated result
  always_ff @(posedge clk)
    if (w_flush) begin
      r_acc <= '0;
      r_idx <= '0;
      dout  <= '0;
      clip  <= 1'b0;
    end else begin
      if (r_state == SM_GET_INPUT && din_valid) begin
        r_acc <= '0;
        r_idx <= '0;
        for (int k = 0; k < G_NUM_CH; k++) begin
          r_din[k]  <= ch_mask[k] ? din[k] : '0;
          r_gain[k] <= gain[k];
        end
      end
      if (r_state == SM_ACC) begin
        r_acc <= r_acc + w_sum;
        r_idx <= r_idx + IW'(G_LANES);
      end
      if (r_state == SM_SCALE) begin
        dout <= w_dout;
        clip <= w_clip;
      end
    end
  // Saturating clip counter; survives enable drop, clear beats increment
  always_ff @(posedge clk)
    if (reset || clip_count_clr)
      clip_count <= '0;
    else if (enable && r_state == SM_SCALE && w_clip && clip_count != '1)
      clip_count <= clip_count + G_CNT_WIDTH'(1);
endmodule

// File: tb/tb_slow_mix_sat.sv
// tb_slow_mix_sat: directed self-checking bench for slow_mix_sat
module tb_slow_mix_sat;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b1, din_valid = 1'b0, dout_ready = 1'b1, clip_count_clr = 1'b0;
  logic signed [15:0] din [4];
  logic signed [15:0] gain [4];
  logic [3:0] ch_mask = '0;
  logic din_ready, clip, dout_valid;
  logic signed [15:0] dout;
  logic [15:0] clip_count;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  slow_mix_sat dut (
    .clk(clk), .reset(reset), .enable(enable), .din(din), .gain(gain), .ch_mask(ch_mask),
    .din_valid(din_valid), .din_ready(din_ready), .dout(dout), .clip(clip), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .clip_count(clip_count), .clip_count_clr(clip_count_clr)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic load(input int d0, input int d1, input int d2, input int d3, input int g0, input logic [3:0] m);
    din[0] = 16'(d0); din[1] = 16'(d1); din[2] = 16'(d2); din[3] = 16'(d3);
    gain[0] = 16'(g0); gain[1] = 16'sd16384; gain[2] = 16'sd16384; gain[3] = 16'sd16384;
    ch_mask = m;
  endtask
  task automatic put(input string tag, input int d0, input int d1, input int d2, input int d3, input int g0, input logic [3:0] m);
    int n = 0;
    load(d0, d1, d2, d3, g0, m);
    din_valid = 1'b1;
    while (!din_ready && n < 20) begin tick; n++; end
    chk({tag, "_ready"}, din_ready, 1);
    tick;
    din_valid = 1'b0;
  endtask
  task automatic res(input string tag, input int ed, input int ec);
    int n = 0;
    while (!dout_valid && n < 20) begin tick; n++; end
    chk({tag, "_valid"}, dout_valid, 1);
    chk({tag, "_dout"}, dout, ed);
    chk({tag, "_clip"}, clip, ec);
    tick;
  endtask
  initial begin
    for (int k = 0; k < 4; k++) begin din[k] = '0; gain[k] = '0; end
    tick; tick;
    chk("rst_din_ready", din_ready, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_clip", clip, 0);
    chk("rst_clip_count", clip_count, 0);
    reset = 1'b0;
    for (int r = 0; r < 2; r++) begin
      put("t1_acc", 100, 200, -50, 25, 16384, 4'b1111);
      chk("t1_lat0", dout_valid, 0);
      tick; tick;
      chk("t1_lat2", dout_valid, 0);
      tick;
      chk("t1_lat3", dout_valid, 1);
      chk("t1_dout", dout, 275);
      chk("t1_clip", clip, 0);
      tick;
      chk("t1_hs_valid", dout_valid, 0);
      chk("t1_hs_ready", din_ready, 1);
    end
    put("t2a", 30000, 30000, 30000, 30000, 16384, 4'b1111);
    res("t2a", 32767, 1);
    chk("t2a_cnt", clip_count, 1);
    put("t2b", -30000, -30000, -30000, -30000, 16384, 4'b1111);
    res("t2b", -32768, 1);
    chk("t2b_cnt", clip_count, 2);
    clip_count_clr = 1'b1;
    tick;
    clip_count_clr = 1'b0;
    chk("t2_clr", clip_count, 0);
    put("t3a", 3, 0, 0, 0, 8192, 4'b1111);
    res("t3a", 2, 0);
    put("t3b", -3, 0, 0, 0, 8192, 4'b1111);
    res("t3b", -1, 0);
    put("t4", 10, 20, 30, 40, 16384, 4'b0101);
    gain[0] = '0;
    res("t4", 40, 0);
    dout_ready = 1'b0;
    put("t5", 1, 2, 3, 4, 16384, 4'b1111);
    for (int n = 0; n < 20 && !dout_valid; n++) tick;
    load(5, 5, 5, 5, 16384, 4'b1111);
    din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("t5_stall_dout", dout, 10);
      chk("t5_stall_clip", clip, 0);
      chk("t5_stall_valid", dout_valid, 1);
      chk("t5_stall_ready", din_ready, 0);
    end
    dout_ready = 1'b1;
    tick;
    chk("t5_hs_valid", dout_valid, 0);
    chk("t5_hs_ready", din_ready, 1);
    tick;
    din_valid = 1'b0;
    chk("t5_accepted", din_ready, 0);
    tick; tick;
    chk("t5_lat2", dout_valid, 0);
    tick;
    chk("t5_lat3", dout_valid, 1);
    chk("t5_dout", dout, 20);
    tick;
    put("t6_rst", 1, 1, 1, 1, 16384, 4'b1111);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("t6_rst_ready", din_ready, 0);
    chk("t6_rst_valid", dout_valid, 0);
    chk("t6_rst_dout", dout, 0);
    chk("t6_rst_clip", clip, 0);
    put("t6_clip", 30000, 30000, 30000, 30000, 16384, 4'b1111);
    res("t6_clip", 32767, 1);
    chk("t6_cnt1", clip_count, 1);
    enable = 1'b0;
    tick; tick;
    chk("t6_en_cnt", clip_count, 1);
    chk("t6_en_dout", dout, 0);
    chk("t6_en_clip", clip, 0);
    chk("t6_en_ready", din_ready, 0);
    enable = 1'b1;
    put("t6_rec", 1, 1, 1, 1, 16384, 4'b1111);
    res("t6_rec", 4, 0);
    chk("t6_rec_cnt", clip_count, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
